// File: rtl/mem_arbiter.sv
// Shares the single-port mem between instruction fetch and load/store.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration on contention.
module mem_arbiter #(
  parameter int MEM_READ_LATENCY = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr_32,
  output logic [31:0]       i_rdata_32,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr_32,
  input  logic [31:0]       d_wdata_32,
  output logic [31:0]       d_rdata_32,
  output logic              d_ack,
  output logic              d_err,
  output logic              i_err,
  output logic [ADDR_W-1:0] m_addr_32,
  output logic [31:0]       m_data_in_32,
  input  logic [31:0]       m_data_out_32,
  output logic              m_rw,
  output logic              m_en,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [2:0] LAT_M1 = 3'(MEM_READ_LATENCY - 1);

  logic [1:0]        state_q;
  logic [2:0]        cnt_q;
  logic              sel_q;
  logic              rw_q;
  logic              gnt_d;
  logic              gnt_i;
  logic [ADDR_W-1:0] win_addr;
  logic              win_rw;
  logic              misal;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_q: 0 = data granted last, 1 = fetch granted last
  logic rr_q;
  assign gnt_d = d_req & (~i_req | rr_q);
`else
  assign gnt_d = d_req;
`endif
  assign gnt_i = i_req & ~gnt_d;

  assign win_addr = gnt_d ? d_addr_32 : i_addr_32;
  assign win_rw   = gnt_d ? d_rw : 1'b1;
  assign misal    = |win_addr[1:0];
  assign busy     = (state_q != S_IDLE);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rr_q <= 1'b0;
    else if (state_q == S_IDLE && (gnt_d || gnt_i))
      rr_q <= gnt_i;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      rw_q         <= 1'b1;
      m_en         <= 1'b0;
      m_rw         <= 1'b1;
      m_addr_32    <= '0;
      m_data_in_32 <= '0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      i_err        <= 1'b0;
      d_err        <= 1'b0;
      i_rdata_32   <= '0;
      d_rdata_32   <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      i_err <= 1'b0;
      d_err <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_d || gnt_i) begin
            sel_q <= gnt_i;
            rw_q  <= win_rw;
            if (misal) begin
              i_ack   <= gnt_i;
              d_ack   <= gnt_d;
              i_err   <= gnt_i;
              d_err   <= gnt_d;
              state_q <= S_RESP;
            end else begin
              m_en      <= 1'b1;
              m_rw      <= win_rw;
              m_addr_32 <= win_addr;
              if (gnt_d)
                m_data_in_32 <= d_wdata_32;
              state_q <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          m_en <= 1'b0;
          if (!rw_q) begin
            i_ack   <= sel_q;
            d_ack   <= ~sel_q;
            state_q <= S_RESP;
          end else begin
            cnt_q   <= LAT_M1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            if (sel_q)
              i_rdata_32 <= m_data_out_32;
            else
              d_rdata_32 <= m_data_out_32;
            i_ack   <= sel_q;
            d_ack   <= ~sel_q;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a latency-accurate mem model.
// Honours MEM_ARB_ROUND_ROBIN_EN when predicting contention order.
module tb_mem_arbiter;

  localparam int LAT = 3;

  typedef struct packed {
    logic        port;
    logic        err;
    logic        rd;
    logic [31:0] data;
  } sb_t;

  logic        clock = 0;
  logic        reset;
  logic        i_req, d_req, d_rw;
  logic [31:0] i_addr_32, d_addr_32, d_wdata_32;
  logic [31:0] i_rdata_32, d_rdata_32;
  logic        i_ack, d_ack, i_err, d_err;
  logic [31:0] m_addr_32, m_data_in_32, m_data_out_32;
  logic        m_rw, m_en, busy;

  logic [31:0] mem    [64];
  logic [31:0] shadow [64];
  logic [31:0] pipe   [LAT];

  sb_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   acks   = 0;
  logic men_seen;
  logic last_fetch;

  always #5 clock = ~clock;

  mem_arbiter #(.MEM_READ_LATENCY(LAT), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr_32(i_addr_32),
    .i_rdata_32(i_rdata_32), .i_ack(i_ack),
    .d_req(d_req), .d_rw(d_rw), .d_addr_32(d_addr_32),
    .d_wdata_32(d_wdata_32), .d_rdata_32(d_rdata_32),
    .d_ack(d_ack), .d_err(d_err), .i_err(i_err),
    .m_addr_32(m_addr_32), .m_data_in_32(m_data_in_32),
    .m_data_out_32(m_data_out_32),
    .m_rw(m_rw), .m_en(m_en), .busy(busy)
  );

  always @(posedge clock) begin
    if (m_en && !m_rw)
      mem[m_addr_32[7:2]] <= m_data_in_32;
    if (m_en && m_rw)
      pipe[0] <= mem[m_addr_32[7:2]];
    for (int i = 1; i < LAT; i++)
      pipe[i] <= pipe[i-1];
  end
  assign m_data_out_32 = pipe[LAT-1];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    sb_t e;
    if (m_en) begin
      men_seen = 1'b1;
      chk("m_en_aligned", {30'b0, m_addr_32[1:0]}, 32'd0);
    end
    if (i_ack || d_ack) begin
      acks++;
      chk("one_ack", {31'b0, i_ack & d_ack}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexp_ack", exp_q.size(), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("ack_port", {31'b0, i_ack}, {31'b0, e.port});
        chk("ack_err", {31'b0, i_ack ? i_err : d_err},
            {31'b0, e.err});
        if (e.rd)
          chk("rdata", i_ack ? i_rdata_32 : d_rdata_32, e.data);
      end
    end
  end

  task automatic push_exp(input logic port, input logic rw,
                          input logic [31:0] a,
                          input logic [31:0] w);
    sb_t e;
    e.port = port;
    e.err  = |a[1:0];
    e.rd   = rw && !e.err;
    e.data = shadow[a[7:2]];
    if (!rw && !e.err)
      shadow[a[7:2]] = w;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input logic port, output int n);
    logic got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      got = port ? i_ack : d_ack;
    end
    if (!got)
      chk("ack_timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic drop(input logic port);
    @(posedge clock); #1;
    if (port) i_req = 1'b0;
    else d_req = 1'b0;
  endtask

  task automatic issue(input logic port, input logic rw,
                       input logic [31:0] a,
                       input logic [31:0] w);
    int n;
    int lat;
    push_exp(port, port ? 1'b1 : rw, a, w);
    @(posedge clock); #1;
    if (port) begin
      i_req = 1'b1; i_addr_32 = a;
    end else begin
      d_req = 1'b1; d_rw = rw;
      d_addr_32 = a; d_wdata_32 = w;
    end
    wait_ack(port, n);
    lat = (|a[1:0]) ? 1 : ((port || rw) ? LAT + 2 : 2);
    chk(port ? "i_latency" : "d_latency", n, lat);
    last_fetch = port;
    drop(port);
    @(negedge clock);
    chk("busy_gap", {31'b0, busy}, 32'd0);
  endtask

  task automatic pair();
    logic ff;
    int   n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ff = ~last_fetch;
`else
    ff = 1'b0;
`endif
    push_exp(ff, 1'b1, ff ? 32'h4 : 32'h0, 32'h0);
    push_exp(~ff, 1'b1, ff ? 32'h0 : 32'h4, 32'h0);
    @(posedge clock); #1;
    d_rw = 1'b1; d_addr_32 = 32'h0;
    i_addr_32 = 32'h4;
    d_req = 1'b1; i_req = 1'b1;
    wait_ack(ff, n);
    drop(ff);
    wait_ack(~ff, n);
    drop(~ff);
    last_fetch = ~ff;
    @(negedge clock);
  endtask

  initial begin
    int n0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    for (int i = 0; i < LAT; i++)
      pipe[i] = '0;
    last_fetch = 1'b0;
    men_seen = 1'b0;
    reset = 1'b1;
    i_req = 1'b1; i_addr_32 = 32'h0;
    d_req = 1'b0; d_rw = 1'b1;
    d_addr_32 = '0; d_wdata_32 = '0;
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("rst_ctl",
          {25'b0, m_en, m_rw, i_ack, d_ack, i_err, d_err, busy},
          32'h20);
      chk("rst_maddr", m_addr_32, 32'h0);
      chk("rst_mdata", m_data_in_32, 32'h0);
      chk("rst_rdata", i_rdata_32 | d_rdata_32, 32'h0);
    end
    i_req = 1'b0;
    reset = 1'b0;

    issue(0, 0, 32'h8, 32'h12341234);
    issue(1, 1, 32'h8, 32'h0);
    issue(0, 0, 32'h0, 32'hABCDABCD);
    issue(0, 0, 32'h4, 32'hDEFADEFA);
    pair();
    pair();

    men_seen = 1'b0;
    issue(0, 0, 32'h6, 32'hFFFFFFFF);
    chk("mis_m_en", {31'b0, men_seen}, 32'd0);
    chk("mis_mem", mem[1], 32'hDEFADEFA);
    issue(1, 1, 32'h4, 32'h0);
    issue(1, 1, 32'h2, 32'h0);
    issue(0, 1, 32'h9, 32'h0);

    n0 = acks;
    @(posedge clock); #1;
    i_req = 1'b1; i_addr_32 = 32'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    last_fetch = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk("rst_mid_busy", {31'b0, busy}, 32'd0);
      chk("rst_mid_men", {31'b0, m_en}, 32'd0);
    end
    i_req = 1'b0;
    reset = 1'b0;
    repeat (LAT + 3) @(negedge clock);
    chk("rst_mid_noack", acks - n0, 32'd0);
    issue(1, 1, 32'h0, 32'h0);

    for (int k = 0; k < 27; k++)
      issue(0, 0, 32'(k * 4), $urandom);
    for (int k = 0; k < 27; k++)
      issue(1, 1, 32'(k * 4), 32'h0);

    repeat (4) @(negedge clock);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
